serial_adder_ctrl: RTL

SERIAL_ADDER_CTRL -- requirements
Module: serial_adder_ctrl

---
 rtl/serial_adder_pkg.sv | 14 +
 rtl/half_adder.sv | 12 +
 rtl/serial_adder_ctrl.sv | 103 ++++++++++
 3 files changed

// File: rtl/serial_adder_pkg.sv
// Shared types and helpers for the bit-serial adder controller.
package serial_adder_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  function automatic int cnt_width(input int w);
    return (w > 1) ? $clog2(w) : 1;
  endfunction

endpackage

// File: rtl/half_adder.sv
// Single-bit half adder, building block of the serial datapath.
module half_adder (
  input  logic a,
  input  logic b,
  output logic s,
  output logic c
);

  assign s = a ^ b;
  assign c = a & b;

endmodule

// File: rtl/serial_adder_ctrl.sv
// Bit-serial adder: one operand bit per clock, LSB first, result published on DONE entry.
//
// state | meaning
// IDLE  | waiting for start; operands captured on the accepting edge
// RUN   | one bit per edge, WIDTH edges in total
// DONE  | one-cycle done pulse, sum/carry_out just updated
module serial_adder_ctrl
  import serial_adder_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] sum,
  output logic             carry_out
);

  localparam int               CNT_W = cnt_width(WIDTH);
  localparam logic [CNT_W-1:0] LAST  = CNT_W'(WIDTH - 1);

  state_t           state;
  state_t           state_nx;
  logic [WIDTH-1:0] op_a;
  logic [WIDTH-1:0] op_b;
  logic [WIDTH-1:0] res;
  logic [WIDTH-1:0] res_nx;
  logic [CNT_W-1:0] cnt;
  logic             carry_q;
  logic             s1;
  logic             c1;
  logic             c2;
  logic             bit_s;
  logic             carry_nx;

  half_adder u_ha0 (.a(op_a[0]), .b(op_b[0]), .s(s1),    .c(c1));
  half_adder u_ha1 (.a(s1),      .b(carry_q), .s(bit_s), .c(c2));

  assign carry_nx = c1 | c2;
  // New bit enters at the MSB so that after WIDTH shifts bit 0 sits at the LSB.
  assign res_nx   = (res >> 1) | (WIDTH'(bit_s) << (WIDTH - 1));

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    case (state)
      IDLE:    if (start) state_nx = RUN;
      RUN:     if (cnt == LAST) state_nx = DONE;
      DONE:    state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      busy      <= 1'b0;
      done      <= 1'b0;
      sum       <= '0;
      carry_out <= 1'b0;
      op_a      <= '0;
      op_b      <= '0;
      res       <= '0;
      cnt       <= '0;
      carry_q   <= 1'b0;
    end else begin
      busy <= (state_nx != IDLE);
      done <= (state_nx == DONE);
      case (state)
        IDLE: begin
          if (start) begin
            op_a    <= a;
            op_b    <= b;
            res     <= '0;
            cnt     <= '0;
            carry_q <= 1'b0;
          end
        end
        RUN: begin
          op_a    <= op_a >> 1;
          op_b    <= op_b >> 1;
          carry_q <= carry_nx;
          res     <= res_nx;
          if (cnt == LAST) begin
            sum       <= res_nx;
            carry_out <= carry_nx;
          end else begin
            cnt <= cnt + CNT_W'(1);
          end
        end
        default: ;
      endcase
    end
  end

endmodule
